// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch inputs, hazard/forwarding controls, writeback port,
// and the decoded operands/control delivered to fetch and execute.
interface decode_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [INSTR_WIDTH-1:0]   i_InstrF;
    logic [ADDRESS_WIDTH-1:0] i_PCPlus4F;
    logic                     i_StallD;
    logic                     i_RegWriteW;
    logic [4:0]               i_WriteRegW;
    logic [DATA_WIDTH-1:0]    i_ResultW;
    logic                     i_ForwardAD;
    logic                     i_ForwardBD;
    logic [DATA_WIDTH-1:0]    i_ALUOutM;

    logic                     o_PCSrcD;
    logic                     o_JumpD;
    logic [ADDRESS_WIDTH-1:0] o_PCBranchD;
    logic [ADDRESS_WIDTH-1:0] o_JumpTargetD;
    logic [DATA_WIDTH-1:0]    o_RD1D;
    logic [DATA_WIDTH-1:0]    o_RD2D;
    logic [4:0]               o_RsD;
    logic [4:0]               o_RtD;
    logic [4:0]               o_RdD;
    logic [DATA_WIDTH-1:0]    o_SignImmD;
    logic                     o_RegWriteD;
    logic                     o_MemtoRegD;
    logic                     o_MemWriteD;
    logic                     o_ALUSrcD;
    logic                     o_RegDstD;
    logic                     o_BranchD;
    logic [2:0]               o_ALUControlD;

    modport master (
        output i_InstrF, i_PCPlus4F, i_StallD, i_RegWriteW, i_WriteRegW,
               i_ResultW, i_ForwardAD, i_ForwardBD, i_ALUOutM,
        input  o_PCSrcD, o_JumpD, o_PCBranchD, o_JumpTargetD, o_RD1D, o_RD2D,
               o_RsD, o_RtD, o_RdD, o_SignImmD, o_RegWriteD, o_MemtoRegD,
               o_MemWriteD, o_ALUSrcD, o_RegDstD, o_BranchD, o_ALUControlD
    );

    modport slave (
        input  i_InstrF, i_PCPlus4F, i_StallD, i_RegWriteW, i_WriteRegW,
               i_ResultW, i_ForwardAD, i_ForwardBD, i_ALUOutM,
        output o_PCSrcD, o_JumpD, o_PCBranchD, o_JumpTargetD, o_RD1D, o_RD2D,
               o_RsD, o_RtD, o_RdD, o_SignImmD, o_RegWriteD, o_MemtoRegD,
               o_MemWriteD, o_ALUSrcD, o_RegDstD, o_BranchD, o_ALUControlD
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: IF/ID register, 32x32 register file with write-first
// bypass, main/ALU control decoder and early branch/jump resolution.
module decode_stage #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    decode_stage_if.slave bus
);
    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'b100000,
        FN_SUB = 6'b100010,
        FN_AND = 6'b100100,
        FN_OR  = 6'b100101,
        FN_SLT = 6'b101010
    } funct_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_e;

    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] pcplus4_q, pcplus4_d;
    logic [DATA_WIDTH-1:0]    rf_q [32];

    logic [4:0]            rs, rt;
    logic [DATA_WIDTH-1:0] rd1, rd2, cmp_a, cmp_b, sign_imm;
    logic                  is_beq, is_bne, is_jump, equal, pcsrc;
    logic                  reg_write, memto_reg, mem_write, alu_src, reg_dst;
    alu_e                  alu_ctl;

    assign rs = instr_q[25:21];
    assign rt = instr_q[20:16];

    // Stall has priority over the taken-branch/jump flush.
    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        if (!bus.i_StallD) begin
            if (pcsrc || is_jump) begin
                instr_d   = '0;
                pcplus4_d = '0;
            end else begin
                instr_d   = bus.i_InstrF;
                pcplus4_d = bus.i_PCPlus4F;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            instr_q   <= '0;
            pcplus4_q <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            if (bus.i_RegWriteW && (bus.i_WriteRegW != 5'd0)) begin
                rf_q[bus.i_WriteRegW] <= bus.i_ResultW;
            end
        end
    end

    // Write-first: a same-cycle writeback to the read address is returned directly.
    always_comb begin
        rd1 = rf_q[rs];
        if (rs == 5'd0) begin
            rd1 = '0;
        end else if (bus.i_RegWriteW && (bus.i_WriteRegW == rs)) begin
            rd1 = bus.i_ResultW;
        end
        rd2 = rf_q[rt];
        if (rt == 5'd0) begin
            rd2 = '0;
        end else if (bus.i_RegWriteW && (bus.i_WriteRegW == rt)) begin
            rd2 = bus.i_ResultW;
        end
    end

    always_comb begin
        reg_write = 1'b0;
        memto_reg = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        reg_dst   = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_jump   = 1'b0;
        alu_ctl   = ALU_AND;
        case (instr_q[31:26])
            OP_RTYPE: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                case (instr_q[5:0])
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: begin
                        reg_write = 1'b0;
                        reg_dst   = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                memto_reg = 1'b1;
                alu_ctl   = ALU_ADD;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = ALU_ADD;
            end
            OP_BEQ: begin
                is_beq  = 1'b1;
                alu_ctl = ALU_SUB;
            end
            OP_BNE: begin
                is_bne  = 1'b1;
                alu_ctl = ALU_SUB;
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = ALU_ADD;
            end
            OP_J:    is_jump = 1'b1;
            default: ;
        endcase
    end

    assign cmp_a    = bus.i_ForwardAD ? bus.i_ALUOutM : rd1;
    assign cmp_b    = bus.i_ForwardBD ? bus.i_ALUOutM : rd2;
    assign equal    = (cmp_a == cmp_b);
    assign pcsrc    = (is_beq && equal) || (is_bne && !equal);
    assign sign_imm = {{(DATA_WIDTH-16){instr_q[15]}}, instr_q[15:0]};

    assign bus.o_PCSrcD      = pcsrc;
    assign bus.o_JumpD       = is_jump;
    assign bus.o_PCBranchD   = pcplus4_q + ADDRESS_WIDTH'(sign_imm << 2);
    assign bus.o_JumpTargetD = {pcplus4_q[ADDRESS_WIDTH-1:ADDRESS_WIDTH-4], instr_q[25:0], 2'b00};
    assign bus.o_RD1D        = rd1;
    assign bus.o_RD2D        = rd2;
    assign bus.o_RsD         = rs;
    assign bus.o_RtD         = rt;
    assign bus.o_RdD         = instr_q[15:11];
    assign bus.o_SignImmD    = sign_imm;
    assign bus.o_RegWriteD   = reg_write;
    assign bus.o_MemtoRegD   = memto_reg;
    assign bus.o_MemWriteD   = mem_write;
    assign bus.o_ALUSrcD     = alu_src;
    assign bus.o_RegDstD     = reg_dst;
    assign bus.o_BranchD     = is_beq || is_bne;
    assign bus.o_ALUControlD = alu_ctl;
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the five-stage pipelined MIPS core, sitting directly downstream of the fetch stage. It owns the IF/ID pipeline register, the 32×32 register file, the main/ALU control decoder, and early branch resolution. It returns PCSrcD, JumpD and the branch target to fetch, and feeds operands and control to the execute stage.

## Interface
- ADDRESS_WIDTH, 32, PC/address width
- INSTR_WIDTH, 32, instruction width
- DATA_WIDTH, 32, register/data width
- i_CLK  in  1  single clock; all state updates on rising edge
- i_RST  in  1  reset, synchronous, active-high
- i_InstrF  in  INSTR_WIDTH  instruction from fetch
- i_PCPlus4F  in  ADDRESS_WIDTH  PC+4 from fetch
- i_StallD  in  1  hazard unit: hold IF/ID register
- i_RegWriteW, i_WriteRegW[4:0], i_ResultW[DATA_WIDTH]  in  writeback port
- i_ForwardAD, i_ForwardBD  in  1 each  select i_ALUOutM for branch comparator A/B
- i_ALUOutM  in  DATA_WIDTH  memory-stage ALU result for branch forwarding
- o_PCSrcD  out  1  branch taken
- o_JumpD  out  1  j instruction in decode
- o_PCBranchD  out  ADDRESS_WIDTH  branch target
- o_JumpTargetD  out  ADDRESS_WIDTH  jump target
- o_RD1D, o_RD2D  out  DATA_WIDTH  register operands (rs, rt)
- o_RsD, o_RtD, o_RdD  out  5 each  instruction fields
- o_SignImmD  out  DATA_WIDTH  sign-extended imm[15:0]
- o_RegWriteD, o_MemtoRegD, o_MemWriteD, o_ALUSrcD, o_RegDstD, o_BranchD  out  1 each  control
- o_ALUControlD  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt

## Operation
- IF/ID register (InstrD, PCPlus4D), priority order: i_RST → both 0; i_StallD → hold; (o_PCSrcD | o_JumpD) → flush, both 0 (NOP bubble); else load i_InstrF / i_PCPlus4F.
- Register file: 32 regs. i_RST clears all to 0. Write on rising edge when i_RegWriteW and i_WriteRegW≠0. Writes to $0 are dropped, and $0 always reads 0.
- Read bypass: if i_RegWriteW and i_WriteRegW==read address≠0, the read returns i_ResultW in the same cycle (write-first).
- Decoder (opcode InstrD[31:26]):
  - 000000 R-type: RegWrite=1, RegDst=1; funct 100000/100010/100100/100101/101010 → ALU 010/110/000/001/111. Any other funct → all controls 0, including sll-0 NOP.
  - 100011 lw: RegWrite, ALUSrc, MemtoReg, ALU 010.
  - 101011 sw: MemWrite, ALUSrc, ALU 010.
  - 000100 beq and 000101 bne: Branch, ALU 110.
  - 001000 addi: RegWrite, ALUSrc, ALU 010.
  - 000010 j: JumpD=1.
  - Unknown opcode → all controls 0.
- Branch: A = i_ForwardAD ? i_ALUOutM : o_RD1D; B likewise with i_ForwardBD. EqualD = (A==B). o_PCSrcD = beq&EqualD | bne&~EqualD.
- o_SignImmD = {{16{InstrD[15]}}, InstrD[15:0]}.
- o_PCBranchD = PCPlus4D + (o_SignImmD<<2), modulo 2^32 (wrap, no overflow flag).
- o_JumpTargetD = {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
- o_RsD/o_RtD/o_RdD = InstrD[25:21]/[20:16]/[15:11].

## Timing
- All outputs are combinational from the IF/ID register, register file and W/M inputs. Decode latency is 1 cycle from fetch.
- After reset: InstrD=0, so all control outputs are 0, o_PCSrcD=o_JumpD=0, o_RD1D=o_RD2D=0, o_SignImmD=0, o_PCBranchD=0, o_JumpTargetD=0.
- A taken branch or jump yields exactly one bubble in the next decode cycle.
- If stall and branch-taken occur together, stall wins and the IF/ID register holds. o_PCSrcD remains valid for fetch.
- Reset asserted mid-stream overrides stall, flush and writeback in that cycle.

## Test plan
- Reset, then idle → all outputs 0; reading any reg returns 0.
- Write $5=0x1234 (W port), then decode add $3,$5,$0 → o_RD1D=0x1234, o_RegWriteD=1, o_RegDstD=1, o_ALUControlD=010. A same-cycle write/read of $5 returns the new value. A write of 0xFFFF to $0 leaves $0 at 0.
- beq $1,$2,-1 with $1=$2=7, PCPlus4D=0x100 → o_PCSrcD=1, o_PCBranchD=0xFC. Next cycle InstrD=0 (bubble). bne with the same operands → o_PCSrcD=0.
- beq with $1=3, $2=9, i_ForwardBD=1, i_ALUOutM=3 → o_PCSrcD=1.
- j 0x0000040 with PCPlus4D=0x40000008 → o_JumpD=1, o_JumpTargetD=0x40000100, then IF/ID flushed.
- i_StallD=1 for 2 cycles while i_InstrF changes → InstrD unchanged. Asserting i_RST during the stall → InstrD=0 and all regs 0 next cycle.
